// File: rtl/usbdev_pkg.sv
// Shared types and default timing for the USB full-speed device link controller.
// Cycle defaults assume the 48 MHz USB clock.
package usbdev_pkg;

  typedef enum logic [2:0] {
    LINK_DISCONNECTED = 3'd0,
    LINK_POWERED      = 3'd1,
    LINK_ACTIVE       = 3'd2,
    LINK_SUSPEND      = 3'd3,
    LINK_ACTIVE_NOSOF = 3'd4
  } link_state_e;

  localparam int unsigned DEFAULT_PWR_DEBOUNCE_CYCLES = 480;     // 10 us
  localparam int unsigned DEFAULT_RESET_CYCLES        = 120;     // 2.5 us
  localparam int unsigned DEFAULT_IDLE_CYCLES         = 144000;  // 3 ms
  localparam int unsigned DEFAULT_RESUME_CYCLES       = 48;      // 1 us

endpackage

// File: rtl/usbdev_debounce.sv
// Level debouncer: the output follows the input only after the input has
// differed from it for Cycles consecutive clocks.
module usbdev_debounce
  import usbdev_pkg::*;
#(
  parameter int unsigned Width  = 1,
  parameter int unsigned Cycles = DEFAULT_PWR_DEBOUNCE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o   <= '0;
      cnt_q <= '0;
    end else if (d_i != q_o) begin
      if (cnt_q == CntLast) begin
        q_o   <= d_i;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/usbdev_link_ctrl.sv
// USB full-speed device link sequencer: VBUS debounce, D+ pull-up control,
// bus reset / suspend / resume detection from the received line state.
//
// state        | meaning
// DISCONNECTED | no VBUS or not enabled, pull-up off
// POWERED      | VBUS ok and connect requested, pull-up on, awaiting bus reset
// ACTIVE       | enumerated traffic expected
// SUSPEND      | bus idle for 3 ms, I/O in suspend
module usbdev_link_ctrl
  import usbdev_pkg::*;
#(
  parameter int unsigned PwrDebounceCycles = DEFAULT_PWR_DEBOUNCE_CYCLES,
  parameter int unsigned ResetCycles       = DEFAULT_RESET_CYCLES,
  parameter int unsigned IdleCycles        = DEFAULT_IDLE_CYCLES,
  parameter int unsigned ResumeCycles      = DEFAULT_RESUME_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       connect_en_i,
  input  logic       usb_pwr_sense_i,
  input  logic       usb_rx_d_i,
  input  logic       usb_rx_se0_i,
  input  logic       usb_tx_oe_i,
  output logic       usb_pullup_en_o,
  output logic       usb_suspend_o,
  output logic [2:0] link_state_o,
  output logic       link_reset_o,
  output logic       rst_evt_o,
  output logic       suspend_evt_o,
  output logic       resume_evt_o,
  output logic       disconnect_evt_o
);

  localparam int unsigned Se0W = $clog2(ResetCycles + 1);
  localparam int unsigned JW   = $clog2(IdleCycles + 1);
  localparam int unsigned KW   = $clog2(ResumeCycles + 1);
  localparam logic [Se0W-1:0] Se0Max = Se0W'(ResetCycles);
  localparam logic [Se0W-1:0] Se0Pre = Se0W'(ResetCycles - 1);
  localparam logic [JW-1:0]   JMax   = JW'(IdleCycles);
  localparam logic [JW-1:0]   JPre   = JW'(IdleCycles - 1);
  localparam logic [KW-1:0]   KMax   = KW'(ResumeCycles);
  localparam logic [KW-1:0]   KPre   = KW'(ResumeCycles - 1);

  logic            pwr_ok;
  link_state_e     state_q, state_d;
  logic [Se0W-1:0] se0_cnt_q;
  logic [JW-1:0]   j_cnt_q;
  logic [KW-1:0]   k_cnt_q;
  logic            se0_hit_q, j_hit_q, k_hit_q;
  logic            line_se0, line_j, line_k, link_off;
  logic            rst_evt_d, suspend_evt_d, resume_evt_d, disconnect_evt_d;

  usbdev_debounce #(
    .Width (1),
    .Cycles(PwrDebounceCycles)
  ) u_pwr_debounce (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (usb_pwr_sense_i),
    .q_o   (pwr_ok)
  );

  assign line_se0 = usb_rx_se0_i;
  assign line_j   = !usb_rx_se0_i && usb_rx_d_i;
  assign line_k   = !usb_rx_se0_i && !usb_rx_d_i;
  assign link_off = !pwr_ok || !connect_en_i || (state_q == LINK_DISCONNECTED);

  // Hit flags pulse on the single clock a run length first reaches its
  // threshold; saturation keeps a long episode from re-qualifying.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      se0_cnt_q <= '0;
      j_cnt_q   <= '0;
      k_cnt_q   <= '0;
      se0_hit_q <= 1'b0;
      j_hit_q   <= 1'b0;
      k_hit_q   <= 1'b0;
    end else if (usb_tx_oe_i || link_off) begin
      se0_cnt_q <= '0;
      j_cnt_q   <= '0;
      k_cnt_q   <= '0;
      se0_hit_q <= 1'b0;
      j_hit_q   <= 1'b0;
      k_hit_q   <= 1'b0;
    end else begin
      se0_cnt_q <= !line_se0 ? '0 : (se0_cnt_q == Se0Max) ? se0_cnt_q : se0_cnt_q + Se0W'(1);
      j_cnt_q   <= !line_j   ? '0 : (j_cnt_q == JMax)     ? j_cnt_q   : j_cnt_q + JW'(1);
      k_cnt_q   <= !line_k   ? '0 : (k_cnt_q == KMax)     ? k_cnt_q   : k_cnt_q + KW'(1);
      se0_hit_q <= line_se0 && (se0_cnt_q == Se0Pre);
      j_hit_q   <= line_j && (j_cnt_q == JPre);
      k_hit_q   <= line_k && (k_cnt_q == KPre);
    end
  end

  always_comb begin
    state_d          = state_q;
    rst_evt_d        = 1'b0;
    suspend_evt_d    = 1'b0;
    resume_evt_d     = 1'b0;
    disconnect_evt_d = 1'b0;
    unique case (state_q)
      LINK_DISCONNECTED: begin
        if (pwr_ok && connect_en_i) state_d = LINK_POWERED;
      end
      LINK_POWERED, LINK_ACTIVE, LINK_SUSPEND: begin
        if (!pwr_ok) begin
          state_d          = LINK_DISCONNECTED;
          disconnect_evt_d = 1'b1;
        end else if (!connect_en_i) begin
          state_d = LINK_DISCONNECTED;
        end else if (se0_hit_q) begin
          state_d   = LINK_ACTIVE;
          rst_evt_d = 1'b1;
        end else if (state_q == LINK_SUSPEND) begin
          if (k_hit_q) begin
            state_d      = LINK_ACTIVE;
            resume_evt_d = 1'b1;
          end
        end else if (j_hit_q) begin
          state_d       = LINK_SUSPEND;
          suspend_evt_d = 1'b1;
        end
      end
      default: state_d = LINK_DISCONNECTED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= LINK_DISCONNECTED;
      usb_pullup_en_o  <= 1'b0;
      usb_suspend_o    <= 1'b0;
      link_reset_o     <= 1'b0;
      rst_evt_o        <= 1'b0;
      suspend_evt_o    <= 1'b0;
      resume_evt_o     <= 1'b0;
      disconnect_evt_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      usb_pullup_en_o  <= (state_d != LINK_DISCONNECTED);
      usb_suspend_o    <= (state_d == LINK_SUSPEND);
      link_reset_o     <= (state_d != LINK_DISCONNECTED) && (se0_cnt_q == Se0Max);
      rst_evt_o        <= rst_evt_d;
      suspend_evt_o    <= suspend_evt_d;
      resume_evt_o     <= resume_evt_d;
      disconnect_evt_o <= disconnect_evt_d;
    end
  end

  assign link_state_o = state_q;

endmodule

// File: doc/usbdev_link_ctrl.md
Name: usbdev_link_ctrl

Overview:
- Sequences the USB full-speed link for the device: debounces VBUS sense, controls the D+ pull-up, detects bus reset, idle-suspend and resume from the received line state.
- Sits in the 48 MHz USB domain between the USB I/O mux (synchronised rx d/se0, pwr sense, pull-up/suspend outputs) and the protocol engine and register block.
- Drives the mux's pull-up enable and suspend inputs; reports link state and events to software.

Parameters:
PwrDebounceCycles, 480, cycles pwr_sense must be stable before it is accepted (10 us at 48 MHz)
ResetCycles, 120, consecutive SE0 cycles that qualify a bus reset (2.5 us)
IdleCycles, 144000, consecutive J cycles that qualify suspend (3 ms)
ResumeCycles, 48, consecutive K cycles in SUSPEND that qualify resume (1 us)

Ports:
clk_i  in  1  48 MHz USB clock
rst_ni  in  1  async active-low reset
connect_en_i  in  1  software connect request
usb_pwr_sense_i  in  1  synchronised VBUS sense
usb_rx_d_i  in  1  synchronised rx data (1 = J)
usb_rx_se0_i  in  1  synchronised rx SE0
usb_tx_oe_i  in  1  device transmitting; line monitors held
usb_pullup_en_o  out  1  D+ pull-up enable to I/O mux
usb_suspend_o  out  1  suspend to I/O mux
link_state_o  out  3  link state encoding
link_reset_o  out  1  level, high while qualified bus reset persists
rst_evt_o  out  1  1-cycle pulse, reset qualified
suspend_evt_o  out  1  1-cycle pulse, entered SUSPEND
resume_evt_o  out  1  1-cycle pulse, left SUSPEND by resume
disconnect_evt_o  out  1  1-cycle pulse, pwr lost while connected

Behaviour:
- Interface: one clock clk_i; reset rst_ni asynchronous, active-low. All flops reset asynchronously; all outputs 0 in reset, link_state_o = DISCONNECTED.
- Power debounce: pwr_ok register; a counter reloads on any change of usb_pwr_sense_i vs pwr_ok and counts up while different; at PwrDebounceCycles-1 pwr_ok takes the new value and the counter clears. Glitches shorter than PwrDebounceCycles are ignored.
- Line class per cycle: SE0 = se0; J = !se0 & d; K = !se0 & !d.
- Line counters: se0_cnt, j_cnt, k_cnt saturating, width $clog2(max+1); each clears when its class is absent. While usb_tx_oe_i = 1, all three clear and hold.
- States (link_state_o): DISCONNECTED=0, POWERED=1, ACTIVE=2, SUSPEND=3, ACTIVE_NOSOF reserved (never driven).
- DISCONNECTED: pull-up off. pwr_ok & connect_en_i -> POWERED next cycle.
- POWERED: pull-up on. se0_cnt reaches ResetCycles -> ACTIVE with rst_evt_o. j_cnt reaches IdleCycles -> SUSPEND.
- ACTIVE: pull-up on. se0_cnt == ResetCycles -> rst_evt_o, stay ACTIVE. j_cnt == IdleCycles -> SUSPEND, suspend_evt_o.
- SUSPEND: usb_suspend_o = 1. k_cnt == ResumeCycles -> ACTIVE, resume_evt_o. se0_cnt == ResetCycles -> ACTIVE, rst_evt_o, no resume_evt_o.
- Event pulses:
  - rst_evt_o fires once per SE0 episode, on the cycle the count reaches ResetCycles; the counter saturates, so no refire.
  - link_reset_o = 1 while se0_cnt == ResetCycles.
  - Suspend qualifies once per J episode.
- Priority, any connected state:
  - !pwr_ok -> DISCONNECTED with disconnect_evt_o; highest priority.
  - Else !connect_en_i -> DISCONNECTED without event.
  - Else reset qualification beats suspend/resume.
- Mid-operation drop of connect_en_i or pwr_ok: the line counters also clear that cycle.
- Outputs are registered; state-change effects appear 1 cycle after the qualifying count.

Decomposition:
- usbdev_pkg holds the link_state_e enum (3 bits) and the default cycle constants.
- One sub-module, usbdev_debounce (Width, Cycles), instanced for pwr sense.
- Line counters and FSM stay inline.

Test Plan:
- Power-up: rst_ni low -> all outputs 0. pwr_sense=1 for 480 cycles with connect_en=1 -> pwr_ok; POWERED and pullup_en=1 one cycle after.
- Glitch: pwr_sense=1 pulse of 479 cycles -> stays DISCONNECTED, pullup_en=0.
- Bus reset: in POWERED drive SE0 for 119 cycles -> no event. Drive SE0 for 300 cycles -> exactly one rst_evt_o, ACTIVE, link_reset_o high until SE0 ends.
- Suspend/resume: ACTIVE with J for 144000 cycles -> suspend_evt_o, suspend_o=1. Then K for 48 cycles -> resume_evt_o, ACTIVE, suspend_o=0. K for 47 cycles then J -> stays SUSPEND.
- TX masking: usb_tx_oe_i=1 with J held 200000 cycles -> no suspend. After oe drops, the full 144000 cycles are needed again.
- Disconnect priority: in SUSPEND, drop pwr_sense for 480 cycles while SE0 is also qualifying -> disconnect_evt_o only, DISCONNECTED, pullup_en=0, suspend_o=0.
